// File: rtl/wm8731_cfg_if.sv
// Handshake bundle between the WM8731 configuration sequencer and the IIC write engine.
// The sequencer drives frame/start; the engine answers with idle/ack.
interface wm8731_cfg_if;
    logic [23:0] iic_data;
    logic        iic_start;
    logic        iic_idle;
    logic        iic_ack_n;

    modport master (
        output iic_data,
        output iic_start,
        input  iic_idle,
        input  iic_ack_n
    );

    modport slave (
        input  iic_data,
        input  iic_start,
        output iic_idle,
        output iic_ack_n
    );
endinterface

// File: rtl/wm8731_cfg.sv
// WM8731 power-up configuration sequencer: walks an 11-entry register table through
// the IIC write engine, retrying NACKed or timed-out writes, and flags done/error.
module wm8731_cfg #(
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int unsigned DELAY_CYC = 50000,
    parameter int unsigned GAP_CYC   = 500,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic         clk_in,
    input  logic         rst,
    wm8731_cfg_if.master iic,
    input  logic         cfg_restart,
    output logic [3:0]   cfg_index,
    output logic         cfg_done,
    output logic         cfg_err
);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_BUSY  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [15:0] DELAY_LAST   = 16'(DELAY_CYC - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'd15;
    localparam logic [1:0]  RETRY_LIM    = 2'(RETRY_MAX);
    localparam logic [3:0]  LAST_INDEX   = 4'd10;

    logic [2:0]  state;
    logic [15:0] delay_cnt;
    logic [15:0] gap_cnt;
    logic [1:0]  retry_cnt;
    logic        timeout;
    logic [23:0] data_q;
    logic        start_q;
    logic [15:0] table_word;

    assign iic.iic_data  = data_q;
    assign iic.iic_start = start_q;

    always_comb begin
        table_word = 16'h0000;
        case (cfg_index)
            4'd0:    table_word = 16'h1E00;
            4'd1:    table_word = 16'h0C00;
            4'd2:    table_word = 16'h0017;
            4'd3:    table_word = 16'h0217;
            4'd4:    table_word = 16'h0479;
            4'd5:    table_word = 16'h0679;
            4'd6:    table_word = 16'h0812;
            4'd7:    table_word = 16'h0A00;
            4'd8:    table_word = 16'h0E02;
            4'd9:    table_word = 16'h1000;
            4'd10:   table_word = 16'h1201;
            default: table_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_WAIT;
            delay_cnt <= '0;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            timeout   <= 1'b0;
            data_q    <= '0;
            start_q   <= 1'b0;
            cfg_index <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (delay_cnt == DELAY_LAST) begin
                        delay_cnt <= '0;
                        state     <= S_LOAD;
                    end else begin
                        delay_cnt <= delay_cnt + 16'd1;
                    end
                end
                // Frame is written every LOAD cycle, so it is already valid when start rises.
                S_LOAD: begin
                    data_q <= {DEV_ADDR, table_word};
                    if (iic.iic_idle) begin
                        start_q <= 1'b1;
                        gap_cnt <= '0;
                        timeout <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (!iic.iic_idle) begin
                        start_q <= 1'b0;
                        state   <= S_BUSY;
                    end else if (gap_cnt == TIMEOUT_LAST) begin
                        start_q <= 1'b0;
                        timeout <= 1'b1;
                        state   <= S_CHECK;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_BUSY: begin
                    if (iic.iic_idle) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    gap_cnt <= '0;
                    if (!iic.iic_ack_n && !timeout) begin
                        retry_cnt <= '0;
                        if (cfg_index == LAST_INDEX) begin
                            cfg_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            cfg_index <= cfg_index + 4'd1;
                            state     <= S_GAP;
                        end
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        state     <= S_GAP;
                    end else begin
                        cfg_err <= 1'b1;
                        state   <= S_ERR;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (cfg_restart) begin
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                        cfg_index <= '0;
                        retry_cnt <= '0;
                        delay_cnt <= '0;
                        state     <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_wm8731_cfg.sv
// Scoreboard bench for wm8731_cfg: a behavioural IIC engine answers each request,
// expected frames are queued by the stimulus and checked by a monitor on every start edge.
module tb_wm8731_cfg;

    localparam int GAP = 4;
    localparam int M_ACK = 0, M_NACK3 = 1, M_NACK5 = 2, M_STUCK = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_restart;
    logic [3:0] cfg_index;
    logic       cfg_done;
    logic       cfg_err;

    wm8731_cfg_if bus();

    wm8731_cfg #(
        .DEV_ADDR (8'h34),
        .DELAY_CYC(20),
        .GAP_CYC  (GAP),
        .RETRY_MAX(3)
    ) dut (
        .clk_in     (clk),
        .rst        (rst),
        .iic        (bus),
        .cfg_restart(cfg_restart),
        .cfg_index  (cfg_index),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] frames [11] = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217,
                                 24'h340479, 24'h340679, 24'h340812, 24'h340A00,
                                 24'h340E02, 24'h341000, 24'h341201};

    logic [23:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int mode = M_ACK;
    bit nacked3 = 0;
    bit gap_en = 1;
    bit gap_pending = 0;
    int idle_rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(frames[i]);
    endtask

    task automatic push_n(input int idx, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(frames[idx]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input int max);
        int n = 0;
        while (!(cfg_done || cfg_err) && n < max) begin
            step();
            n++;
        end
        check("end_reached", 32'(cfg_done | cfg_err), 32'd1);
    endtask

    task automatic pulse_restart();
        gap_pending = 0;
        cfg_restart = 1'b1;
        step();
        cfg_restart = 1'b0;
    endtask

    // Behavioural IIC engine: idle falls 3 cycles after start, busy 5 cycles.
    initial begin : engine
        logic [23:0] frame;
        bus.iic_idle  = 1'b0;
        bus.iic_ack_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 bus.iic_idle = 1'b1;
        forever begin
            step();
            if (bus.iic_start && mode != M_STUCK) begin
                frame = bus.iic_data;
                repeat (3) @(posedge clk);
                #1 bus.iic_idle = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.iic_ack_n = (mode == M_NACK3 && frame == 24'h340217 && !nacked3) ||
                                (mode == M_NACK5 && frame == 24'h340679);
                if (mode == M_NACK3 && frame == 24'h340217) nacked3 = 1;
                bus.iic_idle = 1'b1;
                if (gap_en) begin
                    idle_rise_cyc = cyc;
                    gap_pending = 1;
                end
            end
        end
    end

    // Monitor: every rising start presents a frame to the scoreboard.
    initial begin : monitor
        logic prev = 1'b0;
        int width = 0;
        forever begin
            step();
            if (bus.iic_start && !prev) begin
                width = 1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", bus.iic_data);
                end else begin
                    check("frame", 32'(bus.iic_data), 32'(exp_q.pop_front()));
                end
                if (gap_pending) begin
                    check("gap_latency", 32'(cyc - idle_rise_cyc), 32'(GAP + 3));
                    gap_pending = 0;
                end
            end else if (bus.iic_start) begin
                width++;
            end
            if (!bus.iic_start && prev && mode == M_STUCK)
                check("start_width", 32'(width), 32'd16);
            prev = bus.iic_start;
        end
    end

    initial begin : stimulus
        int n;
        int viol;
        rst = 1'b1;
        cfg_restart = 1'b0;
        repeat (3) step();
        check("rst_data", 32'(bus.iic_data), 32'h0);
        check("rst_start", 32'(bus.iic_start), 32'h0);
        check("rst_index", 32'(cfg_index), 32'h0);
        check("rst_done", 32'(cfg_done), 32'h0);
        check("rst_err", 32'(cfg_err), 32'h0);

        // All writes ACKed
        push_range(0, 10);
        rst = 1'b0;
        wait_end(3000);
        check("t1_done", 32'(cfg_done), 32'd1);
        check("t1_err", 32'(cfg_err), 32'd0);
        check("t1_index", 32'(cfg_index), 32'd10);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Entry 3 NACKed once; a restart pulse mid-transfer must be ignored
        mode = M_NACK3;
        pulse_restart();
        check("t2_done_cleared", 32'(cfg_done), 32'd0);
        check("t2_index_cleared", 32'(cfg_index), 32'd0);
        push_range(0, 3);
        push_n(3, 1);
        push_range(4, 10);
        n = 0;
        while (!(cfg_index == 4'd5 && bus.iic_start) && n < 3000) begin
            step();
            n++;
        end
        check("t2_reach_idx5", 32'(cfg_index == 4'd5 && bus.iic_start), 32'd1);
        cfg_restart = 1'b1;
        step();
        cfg_restart = 1'b0;
        check("t2_restart_ignored_idx", 32'(cfg_index), 32'd5);
        wait_end(3000);
        check("t2_done", 32'(cfg_done), 32'd1);
        check("t2_err", 32'(cfg_err), 32'd0);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // Entry 5 always NACKed: four attempts then error
        mode = M_NACK5;
        pulse_restart();
        push_range(0, 4);
        push_n(5, 4);
        wait_end(3000);
        check("t3_err", 32'(cfg_err), 32'd1);
        check("t3_done", 32'(cfg_done), 32'd0);
        check("t3_index", 32'(cfg_index), 32'd5);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.iic_start) viol++;
        end
        check("t3_no_start_after_err", 32'(viol), 32'd0);
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // Engine never leaves idle: four 16-cycle timeouts on entry 0
        mode = M_STUCK;
        pulse_restart();
        push_n(0, 4);
        wait_end(3000);
        check("t4_err", 32'(cfg_err), 32'd1);
        check("t4_index", 32'(cfg_index), 32'd0);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // Reset while entry 7 is in flight, then full rerun
        mode = M_ACK;
        pulse_restart();
        push_range(0, 7);
        n = 0;
        while (!(cfg_index == 4'd7 && !bus.iic_start && !bus.iic_idle) && n < 3000) begin
            step();
            n++;
        end
        check("t5_reach_busy7", 32'(cfg_index == 4'd7 && !bus.iic_idle), 32'd1);
        gap_en = 0;
        gap_pending = 0;
        rst = 1'b1;
        step();
        check("t5_rst_data", 32'(bus.iic_data), 32'h0);
        check("t5_rst_start", 32'(bus.iic_start), 32'h0);
        check("t5_rst_index", 32'(cfg_index), 32'h0);
        check("t5_rst_done", 32'(cfg_done | cfg_err), 32'h0);
        check("t5_queue_pre", 32'(exp_q.size()), 32'd0);
        step();
        push_range(0, 10);
        rst = 1'b0;
        wait_end(3000);
        check("t5_done", 32'(cfg_done), 32'd1);
        check("t5_index", 32'(cfg_index), 32'd10);
        check("t5_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
